ldm_stm_register_reader: RTL and testbench
==========================================

Name: ldm_stm_register_reader

Overview:
- Store-multiple (STM) sequencer that reads a 16-bit register list out of the register file through read port A, one register per transfer.
- Presents each value with its computed address to the memory interface over a valid/ready handshake.
- Optionally writes the updated base address back through the register-file write port.
- Sits between the instruction control unit and the register file / memory interface.

Parameters:
- DATA_WIDTH, 32, width of register data and addresses
- NREGS, 16, number of architectural registers (bits in REGLIST)
- SEL_WIDTH, 4, width of register selectors (log2 NREGS)

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST  input  1  reset, asynchronous, active-high
- START  input  1  single-cycle request pulse; sampled only in IDLE
- REGLIST  input  16  register list, bit i = register Ri; captured on START
- BASE  input  32  base address; captured on START
- BASE_REG  input  4  index of base register for writeback; captured on START
- MODE  input  2  addressing mode: 0=IA, 1=IB, 2=DA, 3=DB; captured on START
- WB  input  1  base writeback enable; captured on START
- RA  output  4  register-file A-mux selector
- RFE  output  1  register-file enable, active-low (0 = enabled)
- A_IN  input  32  register-file A output; combinational from RA
- MEM_ADDR  output  32  transfer address
- MEM_DATA  output  32  transfer data
- MEM_VALID  output  1  transfer request
- MEM_READY  input  1  memory accepts when MEM_VALID&&MEM_READY at a rising edge
- RC  output  4  writeback register select
- WB_DATA  output  32  writeback value
- WB_EN  output  1  writeback strobe, one cycle
- BUSY  output  1  high from the cycle after START until DONE, inclusive
- DONE  output  1  one-cycle completion pulse

Behaviour:
- Reset values: RA=0, RFE=1, MEM_ADDR=0, MEM_DATA=0, MEM_VALID=0, RC=0, WB_DATA=0, WB_EN=0, BUSY=0, DONE=0, state=IDLE.
- Reset acts immediately, including mid-transfer: MEM_VALID drops with no handshake completion, and all captured fields are discarded.
- States: IDLE, READ, SEND, FINISH.
- IDLE, START=1:
  - Capture all inputs. N = popcount(REGLIST).
  - First address, modulo 2^32: IA=BASE, IB=BASE+4, DA=BASE-4N+4, DB=BASE-4N.
  - Writeback value: IA/IB=BASE+4N, DA/DB=BASE-4N.
  - Next state is READ if N>0, else FINISH.
- READ (1 cycle):
  - RA = lowest set bit of remaining list; RFE=0.
  - A_IN latched into MEM_DATA at the edge; MEM_ADDR = current address. Go to SEND.
- SEND:
  - MEM_VALID=1; MEM_ADDR, MEM_DATA and RA held stable until handshake.
  - On handshake: clear that bit from the remaining list and add 4 to the address.
  - Go to READ if bits remain, else FINISH.
- FINISH (1 cycle):
  - DONE=1.
  - If WB && N>0: WB_EN=1, RC=BASE_REG, WB_DATA=writeback value.
  - Return to IDLE.
- Registers are always transferred in ascending index order at ascending addresses, regardless of MODE.
- Throughput with MEM_READY tied high: 2 cycles per register. START at edge 0 gives DONE high in cycle 2N+1 (N>0) or cycle 1 (N=0).
- Empty list: no MEM_VALID, no WB_EN, DONE only.
- START while BUSY: ignored, no queuing.
- RFE=1 in every state except READ.
- Address arithmetic wraps silently at 32 bits.
- BASE_REG included in REGLIST: the original (pre-writeback) value is stored.

Decomposition:
- Shared package holds:
  - MODE_IA/IB/DA/DB encodings
  - state encoding constants
  - WORD_BYTES=4
- One natural sub-module: reg_list_scanner. Combinational; outputs lowest-set-bit index, empty flag, and popcount of a 16-bit list.

Test Plan:
- IA, REGLIST=0x0003, BASE=0x100, R0=0xAAAA, R1=0xBBBB, WB=1, BASE_REG=2, READY=1 -> (0x100,0xAAAA) accepted cycle 2, (0x104,0xBBBB) cycle 4, DONE+WB_EN cycle 5, RC=2, WB_DATA=0x108.
- DB, REGLIST=0x8001, BASE=0x200 -> R0 at 0x1F8, R15 at 0x1FC, WB_DATA=0x1F8.
- Backpressure: MEM_READY low 3 cycles during first SEND -> MEM_VALID held, addr/data/RA stable, transfer completes on 4th cycle, total latency +3.
- REGLIST=0x0000, WB=1 -> DONE in cycle 1, MEM_VALID never high, WB_EN never high.
- Wrap: IA, BASE=0xFFFFFFFC, REGLIST=0x0006 -> addresses 0xFFFFFFFC then 0x00000000, WB_DATA=0x00000004.
- RST asserted mid-SEND -> MEM_VALID, BUSY low immediately. A new START after release gives a correct full sequence. START pulsed while BUSY is ignored.

Source files
------------

// File: rtl/ldm_stm_register_reader_pkg.sv
// Shared encodings for the store-multiple sequencer: addressing modes, FSM states, word size.
package ldm_stm_register_reader_pkg;

  localparam logic [1:0] MODE_IA = 2'd0;
  localparam logic [1:0] MODE_IB = 2'd1;
  localparam logic [1:0] MODE_DA = 2'd2;
  localparam logic [1:0] MODE_DB = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_SEND   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/ldm_stm_register_reader_reg_list_scanner.sv
// Combinational scan of a register list: lowest set index, empty flag and population count.
module ldm_stm_register_reader_reg_list_scanner #(
  parameter int NREGS     = 16,
  parameter int SEL_WIDTH = 4,
  parameter int CNT_WIDTH = 5
) (
  input  logic [NREGS-1:0]     list,
  output logic [SEL_WIDTH-1:0] lowest,
  output logic                 empty,
  output logic [CNT_WIDTH-1:0] count
);

  // Descending walk so the last hit recorded is the lowest index.
  always_comb begin
    lowest = '0;
    empty  = 1'b1;
    count  = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (list[i]) begin
        lowest = SEL_WIDTH'(i);
        empty  = 1'b0;
        count  = count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/ldm_stm_register_reader.sv
// Store-multiple sequencer: reads listed registers via port A in ascending order and hands each
// to memory over valid/ready, then optionally writes the updated base back.
module ldm_stm_register_reader
  import ldm_stm_register_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NREGS      = 16,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [NREGS-1:0]      REGLIST,
  input  logic [DATA_WIDTH-1:0] BASE,
  input  logic [SEL_WIDTH-1:0]  BASE_REG,
  input  logic [1:0]            MODE,
  input  logic                  WB,
  output logic [SEL_WIDTH-1:0]  RA,
  output logic                  RFE,
  input  logic [DATA_WIDTH-1:0] A_IN,
  output logic [DATA_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_DATA,
  output logic                  MEM_VALID,
  input  logic                  MEM_READY,
  output logic [SEL_WIDTH-1:0]  RC,
  output logic [DATA_WIDTH-1:0] WB_DATA,
  output logic                  WB_EN,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int CNT_WIDTH = $clog2(NREGS + 1);

  state_t                state_q, state_d;
  logic [NREGS-1:0]      list_q, list_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wb_val_q, wb_val_d;
  logic [SEL_WIDTH-1:0]  base_reg_q, base_reg_d;
  logic                  wb_q, wb_d;
  logic [SEL_WIDTH-1:0]  ra_q, ra_d;
  logic                  rfe_q, rfe_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [SEL_WIDTH-1:0]  rc_q, rc_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  wb_en_q, wb_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [NREGS-1:0]      scan_in;
  logic [SEL_WIDTH-1:0]  scan_low;
  logic                  scan_empty;
  logic [CNT_WIDTH-1:0]  scan_cnt;
  logic [DATA_WIDTH-1:0] span;
  logic [DATA_WIDTH-1:0] word;

  // In IDLE the scanner sizes the incoming list; otherwise it looks at what remains
  // once the register currently on RA has been sent.
  assign scan_in = (state_q == ST_IDLE) ? REGLIST
                                        : (list_q & ~(NREGS'(1) << ra_q));

  ldm_stm_register_reader_reg_list_scanner #(
    .NREGS    (NREGS),
    .SEL_WIDTH(SEL_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_scanner (
    .list  (scan_in),
    .lowest(scan_low),
    .empty (scan_empty),
    .count (scan_cnt)
  );

  assign word = DATA_WIDTH'(WORD_BYTES);
  assign span = DATA_WIDTH'(scan_cnt) * word;

  always_comb begin
    state_d     = state_q;
    list_d      = list_q;
    addr_d      = addr_q;
    wb_val_d    = wb_val_q;
    base_reg_d  = base_reg_q;
    wb_d        = wb_q;
    ra_d        = ra_q;
    rfe_d       = 1'b1;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_valid_d = mem_valid_q;
    rc_d        = rc_q;
    wb_data_d   = wb_data_q;
    wb_en_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          list_d     = REGLIST;
          base_reg_d = BASE_REG;
          wb_d       = WB && !scan_empty;
          busy_d     = 1'b1;
          case (MODE)
            MODE_IA: begin addr_d = BASE;               wb_val_d = BASE + span; end
            MODE_IB: begin addr_d = BASE + word;        wb_val_d = BASE + span; end
            MODE_DA: begin addr_d = BASE - span + word; wb_val_d = BASE - span; end
            default: begin addr_d = BASE - span;        wb_val_d = BASE - span; end
          endcase
          if (scan_empty) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = ST_READ;
            ra_d    = scan_low;
            rfe_d   = 1'b0;
          end
        end
      end
      ST_READ: begin
        mem_data_d  = A_IN;
        mem_addr_d  = addr_q;
        mem_valid_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (MEM_READY) begin
          mem_valid_d = 1'b0;
          list_d      = scan_in;
          addr_d      = addr_q + word;
          if (scan_empty) begin
            state_d   = ST_FINISH;
            done_d    = 1'b1;
            wb_en_d   = wb_q;
            if (wb_q) begin
              rc_d      = base_reg_q;
              wb_data_d = wb_val_q;
            end
          end else begin
            state_d = ST_READ;
            ra_d    = scan_low;
            rfe_d   = 1'b0;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      list_q      <= '0;
      addr_q      <= '0;
      wb_val_q    <= '0;
      base_reg_q  <= '0;
      wb_q        <= 1'b0;
      ra_q        <= '0;
      rfe_q       <= 1'b1;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_valid_q <= 1'b0;
      rc_q        <= '0;
      wb_data_q   <= '0;
      wb_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      list_q      <= list_d;
      addr_q      <= addr_d;
      wb_val_q    <= wb_val_d;
      base_reg_q  <= base_reg_d;
      wb_q        <= wb_d;
      ra_q        <= ra_d;
      rfe_q       <= rfe_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_valid_q <= mem_valid_d;
      rc_q        <= rc_d;
      wb_data_q   <= wb_data_d;
      wb_en_q     <= wb_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign RA        = ra_q;
  assign RFE       = rfe_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_DATA  = mem_data_q;
  assign MEM_VALID = mem_valid_q;
  assign RC        = rc_q;
  assign WB_DATA   = wb_data_q;
  assign WB_EN     = wb_en_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_ldm_stm_register_reader.sv
// Directed, table-driven bench for the store-multiple sequencer.
module tb_ldm_stm_register_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [15:0] REGLIST;
  logic [31:0] BASE;
  logic [3:0]  BASE_REG;
  logic [1:0]  MODE;
  logic        WB;
  logic [3:0]  RA;
  logic        RFE;
  logic [31:0] A_IN;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_DATA;
  logic        MEM_VALID;
  logic        MEM_READY;
  logic [3:0]  RC;
  logic [31:0] WB_DATA;
  logic        WB_EN;
  logic        BUSY;
  logic        DONE;

  always #5 CLK = ~CLK;

  ldm_stm_register_reader dut (
    .CLK(CLK), .RST(RST), .START(START), .REGLIST(REGLIST), .BASE(BASE),
    .BASE_REG(BASE_REG), .MODE(MODE), .WB(WB), .RA(RA), .RFE(RFE), .A_IN(A_IN),
    .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_VALID(MEM_VALID),
    .MEM_READY(MEM_READY), .RC(RC), .WB_DATA(WB_DATA), .WB_EN(WB_EN),
    .BUSY(BUSY), .DONE(DONE)
  );

  logic [31:0] rf [16];
  always_comb A_IN = rf[RA];

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] list;
    logic [31:0] base;
    logic [3:0]  br;
    logic        wb;
    int          stall;
    bit          glitch;
    int          n;
    logic [31:0] first;
    logic [31:0] wbdata;
    bit          exp_wben;
    int          done_cyc;
  } vec_t;

  vec_t vt [9];

  function automatic vec_t mk(logic [1:0] mode, logic [15:0] list, logic [31:0] base,
                              logic [3:0] br, logic wb, int stall, bit glitch, int n,
                              logic [31:0] first, logic [31:0] wbdata, bit exp_wben,
                              int done_cyc);
    vec_t v;
    v.mode = mode; v.list = list; v.base = base; v.br = br; v.wb = wb;
    v.stall = stall; v.glitch = glitch; v.n = n; v.first = first;
    v.wbdata = wbdata; v.exp_wben = exp_wben; v.done_cyc = done_cyc;
    return v;
  endfunction

  function automatic int nth_bit(logic [15:0] l, int k);
    int c = 0;
    for (int i = 0; i < 16; i++) begin
      if (l[i]) begin
        if (c == k) return i;
        c++;
      end
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Cycle k is the interval ending at rising edge k; START is sampled at edge 0.
  task automatic run(input vec_t v);
    int  xfer = 0;
    int  idx;
    bit  done_seen = 0;
    @(negedge CLK);
    START = 1'b1; MODE = v.mode; REGLIST = v.list; BASE = v.base;
    BASE_REG = v.br; WB = v.wb; MEM_READY = 1'b1;
    for (int cyc = 1; cyc <= 100 && !done_seen; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) START = 1'b0;
      if (v.glitch && cyc == 2) begin
        START = 1'b1; REGLIST = 16'hFFFF; BASE = 32'hDEAD_0000; MODE = 2'd3; WB = 1'b1;
      end
      if (v.glitch && cyc == 3) START = 1'b0;
      MEM_READY = (cyc >= 2 && cyc < 2 + v.stall) ? 1'b0 : 1'b1;
      check("busy", {31'b0, BUSY}, 32'd1);
      if (WB_EN && !DONE) check("wb_en_stray", {31'b0, WB_EN}, 32'd0);
      if (MEM_VALID) begin
        if (xfer >= v.n) begin
          check("extra_xfer", 32'(xfer), 32'(v.n - 1));
        end else begin
          idx = nth_bit(v.list, xfer);
          check("mem_addr", MEM_ADDR, v.first + 32'(4 * xfer));
          check("mem_data", MEM_DATA, rf[idx]);
          check("ra", {28'b0, RA}, 32'(idx));
          check("rfe_send", {31'b0, RFE}, 32'd1);
          if (MEM_READY) begin
            check("xfer_cycle", 32'(cyc), 32'(2 * xfer + 2 + v.stall));
            xfer++;
          end
        end
      end
      if (DONE) begin
        done_seen = 1;
        check("done_cycle", 32'(cyc), 32'(v.done_cyc));
        check("xfer_count", 32'(xfer), 32'(v.n));
        check("wb_en", {31'b0, WB_EN}, {31'b0, v.exp_wben});
        if (v.exp_wben) begin
          check("rc", {28'b0, RC}, {28'b0, v.br});
          check("wb_data", WB_DATA, v.wbdata);
        end
      end
    end
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge CLK);
    check("busy_after", {31'b0, BUSY}, 32'd0);
    check("done_after", {31'b0, DONE}, 32'd0);
    @(negedge CLK);
    check("idle_after", {30'b0, BUSY, MEM_VALID}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'hC0DE_0000 | 32'(i);
    rf[0] = 32'h0000_AAAA;
    rf[1] = 32'h0000_BBBB;

    //          mode  list      base          br  wb stall gl  n  first         wbdata        wben done
    vt[0] = mk(2'd0, 16'h0003, 32'h0000_0100, 4'd2,  1, 0, 0, 2,  32'h0000_0100, 32'h0000_0108, 1, 5);
    vt[1] = mk(2'd3, 16'h8001, 32'h0000_0200, 4'd13, 1, 0, 0, 2,  32'h0000_01F8, 32'h0000_01F8, 1, 5);
    vt[2] = mk(2'd1, 16'h0014, 32'h0000_1000, 4'd7,  0, 0, 0, 2,  32'h0000_1004, 32'h0000_1008, 0, 5);
    vt[3] = mk(2'd2, 16'h0007, 32'h0000_0300, 4'd5,  1, 0, 0, 3,  32'h0000_02F8, 32'h0000_02F4, 1, 7);
    vt[4] = mk(2'd0, 16'h0000, 32'h0000_0500, 4'd4,  1, 0, 0, 0,  32'h0000_0500, 32'h0000_0500, 0, 1);
    vt[5] = mk(2'd0, 16'h0006, 32'hFFFF_FFFC, 4'd3,  1, 0, 0, 2,  32'hFFFF_FFFC, 32'h0000_0004, 1, 5);
    vt[6] = mk(2'd0, 16'h0003, 32'h0000_0100, 4'd2,  1, 3, 0, 2,  32'h0000_0100, 32'h0000_0108, 1, 8);
    vt[7] = mk(2'd0, 16'h0004, 32'h0000_0040, 4'd2,  1, 0, 1, 1,  32'h0000_0040, 32'h0000_0044, 1, 3);
    vt[8] = mk(2'd0, 16'hFFFF, 32'h0000_0000, 4'd0,  1, 0, 0, 16, 32'h0000_0000, 32'h0000_0040, 1, 33);

    RST = 1'b1; START = 1'b0; REGLIST = '0; BASE = '0; BASE_REG = '0;
    MODE = '0; WB = 1'b0; MEM_READY = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_ra", {28'b0, RA}, 32'd0);
    check("rst_rfe", {31'b0, RFE}, 32'd1);
    check("rst_addr", MEM_ADDR, 32'd0);
    check("rst_data", MEM_DATA, 32'd0);
    check("rst_valid", {31'b0, MEM_VALID}, 32'd0);
    check("rst_rc", {28'b0, RC}, 32'd0);
    check("rst_wbdata", WB_DATA, 32'd0);
    check("rst_flags", {29'b0, WB_EN, BUSY, DONE}, 32'd0);
    RST = 1'b0;

    for (int i = 0; i < 9; i++) run(vt[i]);

    // Reset while a transfer is being offered, then a full clean sequence.
    @(negedge CLK);
    START = 1'b1; MODE = 2'd0; REGLIST = 16'h0003; BASE = 32'h100; BASE_REG = 4'd2;
    WB = 1'b1; MEM_READY = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    check("midsend_valid", {31'b0, MEM_VALID}, 32'd1);
    RST = 1'b1;
    #1;
    check("midrst_valid", {31'b0, MEM_VALID}, 32'd0);
    check("midrst_busy", {31'b0, BUSY}, 32'd0);
    check("midrst_rfe", {31'b0, RFE}, 32'd1);
    check("midrst_addr", MEM_ADDR, 32'd0);
    @(negedge CLK);
    RST = 1'b0; MEM_READY = 1'b1;
    @(negedge CLK);
    check("post_rst_idle", {30'b0, BUSY, MEM_VALID}, 32'd0);
    run(vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
